plc_input_cond: RTL and testbench

Input conditioning stage for the lathe PLC core. Samples the raw operator-panel pad signals: start/stop push buttons, the sel0 selector and the AUTO/MAN mode switches. Synchronises and debounces each one, then presents clean levels, single-cycle edge pulses and an interlocked operating mode. Its outputs drive the start/stop/sel0/AUTO/MAN inputs of the PLC logic directly downstream.

---
 rtl/plc_in_pkg.sv | 20 ++
 rtl/plc_debounce.sv | 49 ++++
 rtl/plc_input_cond.sv | 116 +++++++++++
 tb/tb_plc_input_cond.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/plc_in_pkg.sv
// Shared types and constants for the lathe PLC operator-panel input stage.
package plc_in_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_AUTO  = 2'b01,
    MODE_MAN   = 2'b10,
    MODE_FAULT = 2'b11
  } mode_t;

  localparam int CH_START = 0;
  localparam int CH_STOP  = 1;
  localparam int CH_SEL0  = 2;
  localparam int CH_AUTO  = 3;
  localparam int CH_MAN   = 4;
  localparam int NUM_CH   = 5;

  localparam int DEBOUNCE_DEFAULT = 1_000_000;

endpackage

// File: rtl/plc_debounce.sv
// One pad channel: 2-flop synchroniser, debounce counter, stable level,
// registered rise pulse and a rejected-transition strobe.
module plc_debounce
  import plc_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic lvl,
  output logic rise,
  output logic glitch
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      lvl  <= 1'b0;
      rise <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      rise <= 1'b0;
      if (s2 == lvl) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        lvl  <= ~lvl;
        rise <= ~lvl;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Sample fell back to the stable level before the count completed.
  assign glitch = (cnt != '0) && (s2 == lvl);

endmodule

// File: rtl/plc_input_cond.sv
// Operator-panel input conditioning: debounce, stop-priority pulses, mode FSM.
// Optional glitch diagnostic counter enabled by PLC_IN_GLITCH_CNT_EN.
module plc_input_cond
  import plc_in_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_in,
  input  logic       stop_in,
  input  logic       sel0_in,
  input  logic       auto_in,
  input  logic       man_in,
  output logic       start_lvl,
  output logic       start_pulse,
  output logic       stop_lvl,
  output logic       stop_pulse,
  output logic       sel0_lvl,
  output logic       auto_o,
  output logic       man_o,
  output logic [1:0] mode,
  output logic       fault,
  output logic [7:0] glitch_cnt
);

  logic [NUM_CH-1:0] pads;
  logic [NUM_CH-1:0] lvl;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] glt;
  logic              a;
  logic              m;
  mode_t             st;

  assign pads[CH_START] = start_in;
  assign pads[CH_STOP]  = stop_in;
  assign pads[CH_SEL0]  = sel0_in;
  assign pads[CH_AUTO]  = auto_in;
  assign pads[CH_MAN]   = man_in;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    plc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (pads[i]),
      .lvl   (lvl[i]),
      .rise  (rise[i]),
      .glitch(glt[i])
    );
  end

  assign start_lvl = lvl[CH_START];
  assign stop_lvl  = lvl[CH_STOP];
  assign sel0_lvl  = lvl[CH_SEL0];
  assign a         = lvl[CH_AUTO];
  assign m         = lvl[CH_MAN];

  // Stop wins: no start pulse while stop is held or rising.
  assign stop_pulse  = rise[CH_STOP];
  assign start_pulse = rise[CH_START] & ~lvl[CH_STOP] & ~rise[CH_STOP];

  logic unused_rise;
  assign unused_rise = ^{rise[CH_SEL0], rise[CH_AUTO], rise[CH_MAN]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= MODE_OFF;
    end else begin
      unique case (st)
        MODE_OFF: begin
          if (a && m)  st <= MODE_FAULT;
          else if (a)  st <= MODE_AUTO;
          else if (m)  st <= MODE_MAN;
        end
        MODE_AUTO: begin
          if (a && m)  st <= MODE_FAULT;
          else if (!a) st <= MODE_OFF;
        end
        MODE_MAN: begin
          if (a && m)  st <= MODE_FAULT;
          else if (!m) st <= MODE_OFF;
        end
        MODE_FAULT: begin
          if (!a && !m) st <= MODE_OFF;
        end
        default: st <= MODE_OFF;
      endcase
    end
  end

  assign mode   = st;
  assign auto_o = (st == MODE_AUTO);
  assign man_o  = (st == MODE_MAN);
  assign fault  = (st == MODE_FAULT);

`ifdef PLC_IN_GLITCH_CNT_EN
  logic [7:0] gcnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gcnt <= 8'h00;
    end else if ((|glt) && (gcnt != 8'hFF)) begin
      gcnt <= gcnt + 8'h01;
    end
  end

  assign glitch_cnt = gcnt;
`else
  logic unused_glt;
  assign unused_glt = |glt;
  assign glitch_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_plc_input_cond.sv
// Self-checking bench for plc_input_cond with DEBOUNCE_CYCLES=4.
module tb_plc_input_cond;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_in, stop_in, sel0_in, auto_in, man_in;
  logic       start_lvl, start_pulse, stop_lvl, stop_pulse, sel0_lvl;
  logic       auto_o, man_o, fault;
  logic [1:0] mode;
  logic [7:0] glitch_cnt;

  int checks = 0;
  int errors = 0;

  logic [9:0] exp_q[$];
  logic [9:0] got;
  logic [9:0] want;

  plc_input_cond #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_in   (start_in),
    .stop_in    (stop_in),
    .sel0_in    (sel0_in),
    .auto_in    (auto_in),
    .man_in     (man_in),
    .start_lvl  (start_lvl),
    .start_pulse(start_pulse),
    .stop_lvl   (stop_lvl),
    .stop_pulse (stop_pulse),
    .sel0_lvl   (sel0_lvl),
    .auto_o     (auto_o),
    .man_o      (man_o),
    .mode       (mode),
    .fault      (fault),
    .glitch_cnt (glitch_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {start_lvl, start_pulse, stop_lvl, stop_pulse, sel0_lvl,
            auto_o, man_o, fault, mode};
  endfunction

  function automatic logic [9:0] mk(logic sl, logic sp, logic tl,
                                    logic tp, logic s0, logic [1:0] md);
    return {sl, sp, tl, tp, s0, md == 2'd1, md == 2'd2, md == 2'd3, md};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pads(logic s, logic t, logic z, logic a, logic m);
    start_in = s;
    stop_in  = t;
    sel0_in  = z;
    auto_in  = a;
    man_in   = m;
  endtask

  task automatic do_reset();
    pads(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  task automatic test_reset();
    pads(1, 1, 1, 1, 1);
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if (obs() !== 10'd0) begin
      errors++;
      $display("FAIL reset_outs got %b want %b", obs(), 10'd0);
    end
    checks++;
    if (glitch_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_glitch got %0d want 0", glitch_cnt);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      exp_q.push_back(mk(c >= 6, 1'b0, c >= 6, c == 6, c >= 6,
                         (c >= 7) ? 2'd3 : 2'd0));
      tick();
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_release cyc %0d got %b want %b", c, got, want);
      end
    end
  endtask

  task automatic test_clean_press();
    for (int c = 1; c <= 20; c++) begin
      pads(c <= 10, 0, 0, 0, 0);
      exp_q.push_back(mk(c >= 6 && c <= 15, c == 6, 0, 0, 0, 2'd0));
      tick();
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL clean_press cyc %0d got %b want %b", c, got, want);
      end
    end
  endtask

  task automatic test_bounce();
    logic [7:0] gexp;
    for (int c = 1; c <= 16; c++) begin
      pads((c <= 10) && (c % 2 == 1), 0, 0, 0, 0);
      exp_q.push_back(mk(0, 0, 0, 0, 0, 2'd0));
      tick();
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL bounce cyc %0d got %b want %b", c, got, want);
      end
    end
`ifdef PLC_IN_GLITCH_CNT_EN
    gexp = 8'd5;
`else
    gexp = 8'd0;
`endif
    checks++;
    if (glitch_cnt !== gexp) begin
      errors++;
      $display("FAIL bounce_glitch got %0d want %0d", glitch_cnt, gexp);
    end
  endtask

  task automatic test_priority();
    for (int c = 1; c <= 10; c++) begin
      pads(1, 1, 0, 0, 0);
      exp_q.push_back(mk(c >= 6, 1'b0, c >= 6, c == 6, 0, 2'd0));
      tick();
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL priority cyc %0d got %b want %b", c, got, want);
      end
    end
  endtask

  task automatic test_mode();
    logic [1:0] me;
    for (int c = 1; c <= 42; c++) begin
      pads(0, 0, 0,
           (c <= 16) || (c >= 25 && c <= 32),
           (c >= 9 && c <= 16) || (c >= 33));
      if (c < 7)       me = 2'd0;
      else if (c < 15) me = 2'd1;
      else if (c < 23) me = 2'd3;
      else if (c < 31) me = 2'd0;
      else if (c < 39) me = 2'd1;
      else if (c < 40) me = 2'd0;
      else             me = 2'd2;
      exp_q.push_back(mk(0, 0, 0, 0, 0, me));
      tick();
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mode cyc %0d got %b want %b", c, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    pads(1, 0, 0, 0, 0);
    tick();
    tick();
    checks++;
    if (start_lvl !== 1'b0) begin
      errors++;
      $display("FAIL mid_pre got %b want 0", start_lvl);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (obs() !== 10'd0) begin
      errors++;
      $display("FAIL mid_in_reset got %b want %b", obs(), 10'd0);
    end
    rst_n = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      exp_q.push_back(mk(r >= 6, r == 6, 0, 0, 0, 2'd0));
      tick();
      got  = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL mid_release cyc %0d got %b want %b", r, got, want);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pads(0, 0, 0, 0, 0);
    tick();
    test_reset();
    do_reset();
    test_clean_press();
    do_reset();
    test_bounce();
    do_reset();
    test_priority();
    do_reset();
    test_mode();
    do_reset();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
